// File: rtl/mem_port_ctrl_pkg.sv
// Shared pipeline definitions: memory-port FSM states, default widths and latency,
// and the latency-counter width rule used by the memory port controller.
package pipe_pkg;

   localparam int ADDR_W_DEF  = 16;
   localparam int DATA_W_DEF  = 16;
   localparam int MEM_LAT_DEF = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      FETCH = 2'd2
   } mem_port_state_t;

   // Counter must hold MEM_LAT-1; a single-cycle port still keeps one bit.
   function automatic int cnt_width(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Bundle of EX/MEM request fields, fetch handshake, memory port and pipeline stall
// shared between the memory port controller and its surroundings.
interface mem_port_ctrl_if
   import pipe_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              memRead_mem;
   logic              memWrite_mem;
   logic [ADDR_W-1:0] ALU_result_mem;
   logic [DATA_W-1:0] Rs_data_mem;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              dm_valid;
   logic [DATA_W-1:0] dm_rdata;
   logic              if_grant;
   logic [DATA_W-1:0] if_rdata;
   logic              stall_pipe;

   modport master (
      input  memRead_mem, memWrite_mem, ALU_result_mem, Rs_data_mem,
      input  if_req, if_addr, mem_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output dm_valid, dm_rdata, if_grant, if_rdata, stall_pipe
   );

   modport slave (
      output memRead_mem, memWrite_mem, ALU_result_mem, Rs_data_mem,
      output if_req, if_addr, mem_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  dm_valid, dm_rdata, if_grant, if_rdata, stall_pipe
   );

endinterface

// File: rtl/mem_port_ctrl_chk.sv
// Protocol properties of the memory port: exclusive completion pulses, writes only
// on an enabled port, and a mandatory idle cycle after every completion.
module mem_port_ctrl_chk (
   input logic clk,
   input logic rst_n,
   input logic mem_en,
   input logic mem_we,
   input logic dm_valid,
   input logic if_grant
);

   a_excl_done: assert property (@(posedge clk) disable iff (!rst_n)
      !(dm_valid && if_grant));

   a_we_needs_en: assert property (@(posedge clk) disable iff (!rst_n)
      mem_we |-> mem_en);

   a_idle_after_done: assert property (@(posedge clk) disable iff (!rst_n)
      (dm_valid || if_grant) |=> !mem_en);

endmodule

// File: rtl/mem_port_ctrl_lat_counter.sv
// Loadable down-counter that tracks the remaining cycles of a memory access;
// it saturates at zero and flags the final access cycle.
module mem_lat_counter #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_r;

   // Remaining-cycle count: load on access start, count down while the port is busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != {W{1'b0}})) begin
         cnt_r <= cnt_r - W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/mem_port_ctrl.sv
// Single-port memory arbiter between instruction fetch and the memory stage:
// round-robin grant, MEM_LAT-cycle access sequencing and pipeline stall generation.
module mem_port_ctrl
   import pipe_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input logic             clk,
   input logic             rst_n,
   mem_port_ctrl_if.master bus
);

   localparam int               CNT_W    = cnt_width(MEM_LAT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   mem_port_state_t   state_r;
   mem_port_state_t   state_next_s;
   logic              last_data_r;
   logic              we_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic              dreq_s;
   logic              grant_data_s;
   logic              grant_fetch_s;
   logic              busy_s;
   logic              zero_s;
   logic              dm_valid_s;
   logic              if_grant_s;

   assign dreq_s = bus.memRead_mem | bus.memWrite_mem;
   assign busy_s = (state_r != IDLE);

   mem_lat_counter #(.W(CNT_W)) u_lat_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (grant_data_s | grant_fetch_s),
      .load_val (CNT_LOAD),
      .dec      (busy_s),
      .zero     (zero_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Arbitration and access sequencing; data wins a tie unless it had the last grant.
   always_comb begin
      state_next_s  = state_r;
      grant_data_s  = 1'b0;
      grant_fetch_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (dreq_s && (!bus.if_req || !last_data_r)) begin
               grant_data_s = 1'b1;
               state_next_s = DATA;
            end else if (bus.if_req) begin
               grant_fetch_s = 1'b1;
               state_next_s  = FETCH;
            end else begin
               state_next_s = IDLE;
            end
         end
         DATA, FETCH: begin
            if (zero_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = state_r;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Access fields are captured at grant so requesters may change them mid-access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r  <= {ADDR_W{1'b0}};
         wdata_r <= {DATA_W{1'b0}};
         we_r    <= 1'b0;
      end else if (grant_data_s) begin
         addr_r  <= bus.ALU_result_mem;
         wdata_r <= bus.Rs_data_mem;
         we_r    <= bus.memWrite_mem;
      end else if (grant_fetch_s) begin
         addr_r  <= bus.if_addr;
         wdata_r <= bus.Rs_data_mem;
         we_r    <= 1'b0;
      end else begin
         addr_r  <= addr_r;
         wdata_r <= wdata_r;
         we_r    <= we_r;
      end
   end

   // Round-robin history: remembers which requester completed last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_data_r <= 1'b0;
      end else if (dm_valid_s) begin
         last_data_r <= 1'b1;
      end else if (if_grant_s) begin
         last_data_r <= 1'b0;
      end else begin
         last_data_r <= last_data_r;
      end
   end

   assign dm_valid_s = (state_r == DATA)  && zero_s;
   assign if_grant_s = (state_r == FETCH) && zero_s;

   assign bus.mem_en     = busy_s;
   assign bus.mem_we     = busy_s & we_r;
   assign bus.mem_addr   = addr_r;
   assign bus.mem_wdata  = wdata_r;
   assign bus.dm_valid   = dm_valid_s;
   assign bus.dm_rdata   = bus.mem_rdata;
   assign bus.if_grant   = if_grant_s;
   assign bus.if_rdata   = bus.mem_rdata;
   assign bus.stall_pipe = dreq_s & ~dm_valid_s;

   mem_port_ctrl_chk u_chk (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem_en   (busy_s),
      .mem_we   (busy_s & we_r),
      .dm_valid (dm_valid_s),
      .if_grant (if_grant_s)
   );

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Scoreboard bench for mem_port_ctrl: stimulus pushes expected grants computed from
// the arbitration rules, a negedge monitor pops and compares each completion.
module tb_mem_port_ctrl;
   import pipe_pkg::*;

   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int LAT = 2;

   typedef struct {
      bit          is_data;
      bit          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   model_last = 1'b0;
   exp_t sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   mem_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

   mem_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   mem_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1));

   function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
      if (a == 16'h0040) return 16'hBEEF;
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   assign bus.mem_rdata  = mem_model(bus.mem_addr);
   assign bus1.mem_rdata = mem_model(bus1.mem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input bit is_data, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int c);
      exp_t e;
      e.is_data = is_data;
      e.we      = we;
      e.addr    = addr;
      e.wdata   = wdata;
      e.rdata   = we ? 16'h0000 : mem_model(addr);
      e.cyc     = c;
      sb_q.push_back(e);
      model_last = is_data;
   endtask

   // Monitor: per-cycle port checks and completion scoreboard.
   initial begin
      int   run_len;
      exp_t e;
      bit   exp_dv;
      run_len = 0;
      forever begin
         @(negedge clk);
         exp_dv = (sb_q.size() > 0) && sb_q[0].is_data && (sb_q[0].cyc == cyc) && rst_n;
         check("stall_pipe", bus.stall_pipe,
               (bus.memRead_mem | bus.memWrite_mem) & ~exp_dv);
         if (!rst_n) begin
            run_len = 0;
         end else begin
            if (bus.mem_en) run_len++;
            if (bus.mem_en && sb_q.size() > 0) begin
               check("access_addr", bus.mem_addr, sb_q[0].addr);
               check("access_we", bus.mem_we, sb_q[0].we);
               if (sb_q[0].we) check("access_wdata", bus.mem_wdata, sb_q[0].wdata);
            end
            if (bus.dm_valid || bus.if_grant) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_completion: actual dm_valid=%0b if_grant=%0b required none",
                           bus.dm_valid, bus.if_grant);
               end else begin
                  e = sb_q.pop_front();
                  check("grant_kind", bus.dm_valid, e.is_data);
                  check("grant_excl", bus.dm_valid & bus.if_grant, 1'b0);
                  check("latency_cycle", cyc, e.cyc);
                  check("en_cycles", run_len, LAT);
                  if (e.is_data && !e.we) check("dm_rdata", bus.dm_rdata, e.rdata);
                  if (!e.is_data) check("if_rdata", bus.if_rdata, e.rdata);
               end
               run_len = 0;
            end
         end
      end
   end

   task automatic clear_reqs();
      bus.memRead_mem  = 1'b0;
      bus.memWrite_mem = 1'b0;
      bus.if_req       = 1'b0;
   endtask

   // Runs until the requested completions occur; requests drop after their completion edge.
   task automatic wait_done(input bit wd, input bit wf);
      bit pd = wd;
      bit pf = wf;
      bit dv;
      bit ig;
      int budget = 0;
      while ((pd || pf) && budget < 4 * LAT + 8) begin
         @(negedge clk);
         dv = bus.dm_valid;
         ig = bus.if_grant;
         @(posedge clk);
         #1;
         if (dv) begin
            bus.memRead_mem  = 1'b0;
            bus.memWrite_mem = 1'b0;
            pd = 1'b0;
         end
         if (ig) begin
            bus.if_req = 1'b0;
            pf = 1'b0;
         end
         budget++;
      end
      if (pd || pf) begin
         checks++;
         errors++;
         $display("FAIL wait_done_timeout: actual pending data=%0b fetch=%0b required none", pd, pf);
         clear_reqs();
         sb_q.delete();
      end
   endtask

   // kind: 0 load, 1 store, 2 fetch, 3 data and fetch together.
   task automatic issue(input int kind, input logic [AW-1:0] daddr, input logic [DW-1:0] wdata,
                        input logic [AW-1:0] pc);
      int  c0 = cyc;
      bit  we = (kind == 1) || (kind == 3 && wdata[0]);
      bit  hasd = (kind != 2);
      bit  hasf = (kind >= 2);
      bus.ALU_result_mem = daddr;
      bus.Rs_data_mem    = wdata;
      bus.if_addr        = pc;
      bus.memRead_mem    = hasd && !we;
      bus.memWrite_mem   = hasd && we;
      bus.if_req         = hasf;
      if (hasd && hasf) begin
         if (!model_last) begin
            push_exp(1'b1, we, daddr, wdata, c0 + LAT);
            push_exp(1'b0, 1'b0, pc, wdata, c0 + 2 * LAT + 1);
         end else begin
            push_exp(1'b0, 1'b0, pc, wdata, c0 + LAT);
            push_exp(1'b1, we, daddr, wdata, c0 + 2 * LAT + 1);
         end
      end else if (hasd) begin
         push_exp(1'b1, we, daddr, wdata, c0 + LAT);
      end else begin
         push_exp(1'b0, 1'b0, pc, wdata, c0 + LAT);
      end
      wait_done(hasd, hasf);
   endtask

   // Fetch held high throughout while four grants' worth of loads are presented.
   task automatic contention();
      logic [AW-1:0] la[4];
      logic [AW-1:0] pc = AW'($urandom);
      int c0 = cyc;
      int di = 0;
      int dn = 0;
      int fn = 0;
      int budget = 0;
      bit dv;
      bit ig;
      for (int i = 0; i < 4; i++) la[i] = AW'($urandom);
      bus.if_req = 1'b1;
      bus.if_addr = pc;
      bus.memRead_mem = 1'b1;
      bus.memWrite_mem = 1'b0;
      bus.ALU_result_mem = la[0];
      for (int g = 0; g < 4; g++) begin
         if (!model_last) begin
            push_exp(1'b1, 1'b0, la[di], 16'h0000, c0 + (g + 1) * (LAT + 1) - 1);
            di++;
         end else begin
            push_exp(1'b0, 1'b0, pc, 16'h0000, c0 + (g + 1) * (LAT + 1) - 1);
         end
      end
      while ((dn < di || fn < 4 - di) && budget < 8 * LAT + 16) begin
         @(negedge clk);
         dv = bus.dm_valid;
         ig = bus.if_grant;
         @(posedge clk);
         #1;
         if (dv) begin
            dn++;
            if (dn < di) bus.ALU_result_mem = la[dn];
            else bus.memRead_mem = 1'b0;
         end
         if (ig) begin
            fn++;
            if (fn >= 4 - di) bus.if_req = 1'b0;
         end
         budget++;
      end
      if (dn < di || fn < 4 - di) begin
         checks++;
         errors++;
         $display("FAIL contention_timeout: actual data=%0d fetch=%0d required data=%0d fetch=%0d",
                  dn, fn, di, 4 - di);
         clear_reqs();
         sb_q.delete();
      end
   endtask

   initial begin
      bus1.memRead_mem = 1'b0; bus1.memWrite_mem = 1'b0; bus1.if_req = 1'b0;
      bus1.ALU_result_mem = 16'h0000; bus1.Rs_data_mem = 16'h0000; bus1.if_addr = 16'h0000;

      // Reset with every request high.
      rst_n = 1'b0;
      bus.memRead_mem = 1'b1; bus.memWrite_mem = 1'b1; bus.if_req = 1'b1;
      bus.ALU_result_mem = 16'h0ABC; bus.Rs_data_mem = 16'h5566; bus.if_addr = 16'h0200;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_en", bus.mem_en, 1'b0);
      check("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_dm_valid", bus.dm_valid, 1'b0);
      check("rst_if_grant", bus.if_grant, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 16'h0000);
      check("rst_mem_wdata", bus.mem_wdata, 16'h0000);
      check("rst_stall", bus.stall_pipe, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_exp(1'b1, 1'b1, 16'h0ABC, 16'h5566, cyc + LAT);
      push_exp(1'b0, 1'b0, 16'h0200, 16'h5566, cyc + 2 * LAT + 1);
      wait_done(1'b1, 1'b1);

      contention();
      issue(0, 16'h0040, 16'h0000, 16'h0000);
      issue(1, 16'h0010, 16'h1234, 16'h0000);

      // Reset during the first cycle of a fetch: no grant, port idle at once.
      bus.if_req = 1'b1;
      bus.if_addr = 16'h0300;
      @(posedge clk);
      #2;
      check("mr_en_before", bus.mem_en, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mr_en_after", bus.mem_en, 1'b0);
      check("mr_if_grant", bus.if_grant, 1'b0);
      bus.if_req = 1'b0;
      model_last = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mr_idle", bus.mem_en, 1'b0);
      @(posedge clk);
      #1;

      // Single-cycle latency instance.
      bus1.memRead_mem = 1'b1;
      bus1.ALU_result_mem = 16'h0040;
      @(negedge clk);
      check("l1_idle_en", bus1.mem_en, 1'b0);
      check("l1_idle_stall", bus1.stall_pipe, 1'b1);
      @(negedge clk);
      check("l1_dm_valid", bus1.dm_valid, 1'b1);
      check("l1_dm_rdata", bus1.dm_rdata, 16'hBEEF);
      check("l1_stall_done", bus1.stall_pipe, 1'b0);
      @(posedge clk);
      #1;
      bus1.memRead_mem = 1'b0;
      bus1.if_req = 1'b1;
      bus1.if_addr = 16'h1357;
      @(negedge clk);
      check("l1_fetch_idle", bus1.if_grant, 1'b0);
      @(negedge clk);
      check("l1_if_grant", bus1.if_grant, 1'b1);
      check("l1_if_rdata", bus1.if_rdata, mem_model(16'h1357));
      @(posedge clk);
      #1;
      bus1.if_req = 1'b0;

      // Randomized traffic.
      for (int t = 0; t < 40; t++) begin
         issue(int'($urandom_range(0, 3)), AW'($urandom), DW'($urandom), AW'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      contention();

      repeat (5) @(posedge clk);
      check("sb_drain", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_ctrl.md
# mem_port_ctrl

Controller that shares the single-port unified memory between the instruction-fetch stage and the memory stage of the five-stage pipeline. It takes the memory-stage control and data fields from the execute/memory pipeline register, arbitrates them against fetch requests, and sequences multi-cycle accesses. It drives `stall_pipe`, which holds every pipeline register while a data access is outstanding.

## Interface
Parameters:
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 16: memory data width.
- `MEM_LAT`, default 2: cycles each access occupies the port; legal range is ≥1.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `memRead_mem`  in  1: data read request from the EX/MEM register.
- `memWrite_mem`  in  1: data write request from the EX/MEM register.
- `ALU_result_mem`  in  ADDR_W: data address.
- `Rs_data_mem`  in  DATA_W: store data.
- `if_req`  in  1: fetch request; held high until `if_grant`.
- `if_addr`  in  ADDR_W: fetch address (PC).
- `mem_en`  out  1: memory port enable.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  ADDR_W: latched access address.
- `mem_wdata`  out  DATA_W: latched store data.
- `mem_rdata`  in  DATA_W: read data, valid in the last access cycle.
- `dm_valid`  out  1: data access completes this cycle.
- `dm_rdata`  out  DATA_W: load data, equal to `mem_rdata` when `dm_valid` is high.
- `if_grant`  out  1: fetch completes this cycle.
- `if_rdata`  out  DATA_W: instruction, equal to `mem_rdata` when `if_grant` is high.
- `stall_pipe`  out  1: hold all pipeline registers.

## Operation
- The FSM has three states: IDLE, DATA and FETCH. The down-counter `cnt` has width ⌈log2(MEM_LAT)⌉, minimum 1. The round-robin bit `last_data` records whether the previous grant went to data.
- `dreq = memRead_mem | memWrite_mem`.
- Behaviour in IDLE:
  - If `dreq` is high and (`if_req` is low or `last_data` = 0), go to DATA.
  - Otherwise, if `if_req` is high, go to FETCH.
  - On entry to either access state: latch the address, latch the write data, latch `we = memWrite_mem` (0 for a fetch), and set `cnt = MEM_LAT-1`.
- In DATA and FETCH:
  - `mem_en` = 1.
  - `mem_we` = the latched `we`.
  - `cnt` decrements each cycle.
  - The completion cycle is `cnt == 0`.
- At completion:
  - DATA asserts `dm_valid` and FETCH asserts `if_grant`. Both are combinational from state and `cnt`.
  - Next state is IDLE, unconditionally; there are no back-to-back grants.
  - `last_data` is set to 1 for a data access and 0 for a fetch.
- `stall_pipe = dreq & ~dm_valid`. It is also high in IDLE and FETCH whenever `dreq` is high.
- Writes also pulse `dm_valid`. `dm_rdata` is don't-care for a write, but is driven as `mem_rdata`.
- Dropping a request mid-access has no effect: the access runs to completion and the completion pulse is still issued.
- When both requesters are pending in IDLE, grants alternate by `last_data`. Data wins after a fetch, and after reset.

## Timing
- Reset values: state IDLE, `cnt` = 0, `last_data` = 0. `mem_en`, `mem_we`, `dm_valid` and `if_grant` are 0. `mem_addr` and `mem_wdata` are 0. `stall_pipe` follows `dreq`.
- Asserting `rst_n` low mid-access aborts the access immediately (asynchronous), with no completion pulse.
- Latency, for a request seen in IDLE at edge E0:
  - `mem_en` is high for cycles E0..E0+MEM_LAT-1.
  - The completion pulse occurs in cycle E0+MEM_LAT-1.
  - Total latency from request to completion is MEM_LAT+1 cycles, including the IDLE cycle.
- `MEM_LAT` = 1 gives a single-cycle access: the completion pulse comes in the first DATA/FETCH cycle.
- Pipeline registers advance on the edge ending a `dm_valid` cycle. The next instruction's request is therefore seen in the following IDLE cycle, so an instruction is never re-issued.

## Structure
- The shared package `pipe_pkg` holds:
  - the state enum `mem_port_state_t` (IDLE, DATA, FETCH);
  - the `MEM_LAT` default;
  - the `ADDR_W`/`DATA_W` defaults shared with the other pipeline-register modules.
- Sub-module `mem_lat_counter`: a loadable down-counter with a `zero` flag, instantiated once.

## Test plan
- **Reset.** Hold `rst_n` = 0 with all requests high. Expect all outputs zero except `stall_pipe` = 1. Release reset: data is granted first.
- **Load, MEM_LAT = 2.**
  - Stimulus: `memRead_mem` = 1, addr 0x0040, `mem_rdata` = 0xBEEF.
  - Expect `mem_en` high for 2 cycles and `mem_we` = 0.
  - Expect `dm_valid` in the 2nd cycle with `dm_rdata` = 0xBEEF.
  - Expect `stall_pipe` high for 2 cycles, then low in the completion cycle.
- **Store.** Stimulus: `memWrite_mem` = 1, addr 0x0010, data 0x1234. Expect `mem_we` = 1, `mem_addr` = 0x0010 and `mem_wdata` = 0x1234 throughout the access, then a `dm_valid` pulse.
- **Contention.** Hold `if_req` = 1 continuously and issue consecutive loads. Expect grants in the order DATA, FETCH, DATA, FETCH, each pair separated by one IDLE cycle. `if_grant` carries the PC's instruction.
- **MEM_LAT = 1 and mid-access reset.**
  - Single-cycle completion pulses are correct.
  - Asserting reset in the 1st cycle of a 2-cycle fetch produces no `if_grant`, and the FSM is IDLE immediately.
